// File: rtl/video_monitor_pkg.sv
// video_monitor shared types and constants.
// FSM encoding and sync-loss timeout helper.
package video_monitor_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    RUN      = 1'b1
  } mon_state_e;

  localparam int CW_DEFAULT = 12;

  // Cycles without an HS falling edge before sync is declared lost.
  function automatic int hs_timeout(input int cw);
    return 1 << cw;
  endfunction

endpackage

// File: rtl/video_if.sv
// Video timing bus between the vga generator and its sinks.
// HS/VS active low, blank high marks an active pixel.
interface video_if;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [23:0] rgb;

  modport master (output hs, vs, blank, rgb);
  modport slave  (input  hs, vs, blank, rgb);
endinterface

// File: rtl/vid_edge_detect.sv
// Two-stage register for one sync bit.
// Rise/fall pulses are decoded from the s1/s2 pair.
module vid_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s1,
  output logic s2,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule

// File: rtl/video_monitor.sv
// Passive checker on the video bus: measures line/frame geometry,
// counts frames and sums RGB over each frame's active pixels.
module video_monitor
  import video_monitor_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int CW    = CW_DEFAULT
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  video_if.slave        video_ifs,
  output logic          locked,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic [CW-1:0] hactive_meas,
  output logic [CW-1:0] vactive_meas,
  output logic          h_err,
  output logic          v_err,
  output logic [31:0]   checksum
);

  localparam logic [CW-1:0] CMAX   = '1;
  localparam logic [CW-1:0] HD     = CW'(HDISP);
  localparam logic [CW-1:0] VD     = CW'(VDISP);
  localparam logic [CW:0]   TMO_M1 = (CW+1)'(hs_timeout(CW) - 1);

  logic hs_s1, hs_s2, hs_rise, hs_fall;
  logic vs_s1, vs_s2, vs_rise, vs_fall;
  logic bl_s1, bl_s2, bl_rise, bl_fall;

  vid_edge_detect u_hs (
    .clk  (pixel_clk),
    .rst  (pixel_rst),
    .d    (video_ifs.hs),
    .s1   (hs_s1),
    .s2   (hs_s2),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  vid_edge_detect u_vs (
    .clk  (pixel_clk),
    .rst  (pixel_rst),
    .d    (video_ifs.vs),
    .s1   (vs_s1),
    .s2   (vs_s2),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  vid_edge_detect u_bl (
    .clk  (pixel_clk),
    .rst  (pixel_rst),
    .d    (video_ifs.blank),
    .s1   (bl_s1),
    .s2   (bl_s2),
    .rise (bl_rise),
    .fall (bl_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, hs_s1, hs_s2, hs_rise,
                       vs_s1, vs_s2, vs_rise, bl_s2, bl_rise};

  logic [23:0]   rgb_s1;
  mon_state_e    state;
  logic [CW-1:0] pix_cnt;
  logic [CW-1:0] line_cnt;
  logic [CW:0]   hs_idle;
  logic [31:0]   sum;

  logic [CW-1:0] pix_next;
  logic [CW-1:0] line_next;
  logic [CW-1:0] line_closed;
  logic          timeout;

  assign pix_next    = (pix_cnt == CMAX) ? pix_cnt : pix_cnt + 1'b1;
  assign line_next   = (line_cnt == CMAX) ? line_cnt : line_cnt + 1'b1;
  // A line closing on the vs_fall cycle still belongs to this frame.
  assign line_closed = bl_fall ? line_next : line_cnt;
  assign timeout     = !hs_fall && (hs_idle == TMO_M1);

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      rgb_s1 <= '0;
    end else begin
      rgb_s1 <= video_ifs.rgb;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state        <= UNLOCKED;
      locked       <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      hactive_meas <= '0;
      vactive_meas <= '0;
      h_err        <= 1'b0;
      v_err        <= 1'b0;
      checksum     <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      hs_idle      <= '0;
      sum          <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        UNLOCKED: begin
          pix_cnt  <= '0;
          line_cnt <= '0;
          hs_idle  <= '0;
          sum      <= '0;
          if (vs_fall) begin
            state  <= RUN;
            locked <= 1'b1;
          end
        end
        RUN: begin
          hs_idle <= hs_fall ? '0 : hs_idle + 1'b1;
          if (timeout) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            sum      <= '0;
          end else begin
            if (bl_s1) begin
              pix_cnt <= pix_next;
              sum     <= sum + {8'h00, rgb_s1};
            end
            if (bl_fall) begin
              hactive_meas <= pix_cnt;
              pix_cnt      <= '0;
              line_cnt     <= line_next;
              if (pix_cnt != HD) h_err <= 1'b1;
            end
            if (vs_fall) begin
              vactive_meas <= line_closed;
              checksum     <= sum;
              frame_done   <= 1'b1;
              frame_count  <= frame_count + 1'b1;
              if (line_closed != VD) v_err <= 1'b1;
              // Partial line cut by vsync is dropped.
              if (bl_s1) h_err <= 1'b1;
              line_cnt <= '0;
              pix_cnt  <= '0;
              sum      <= '0;
            end
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_video_monitor.sv
// Scoreboard bench for video_monitor (HDISP=8, VDISP=4).
// Stimulus pushes expected frame results; a monitor pops on frame_done.
module tb_video_monitor;

  logic        clk;
  logic        rst;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [11:0] hactive_meas;
  logic [11:0] vactive_meas;
  logic        h_err;
  logic        v_err;
  logic [31:0] checksum;

  video_if vif ();

  video_monitor #(
    .HDISP (8),
    .VDISP (4),
    .CW    (12)
  ) dut (
    .pixel_clk    (clk),
    .pixel_rst    (rst),
    .video_ifs    (vif),
    .locked       (locked),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .hactive_meas (hactive_meas),
    .vactive_meas (vactive_meas),
    .h_err        (h_err),
    .v_err        (v_err),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          vact;
    logic [31:0] chk;
    int          fc;
    int          hact;
    bit          herr;
    bit          verr;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  bit          locked_m = 0;
  int          fc_m     = 0;
  bit          herr_m   = 0;
  bit          verr_m   = 0;
  int          lines_m  = 0;
  logic [31:0] sum_m    = 0;
  int          last_h   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic vsync();
    exp_t e;
    if (locked_m) begin
      fc_m++;
      if (lines_m != 4) verr_m = 1;
      e.vact = lines_m;
      e.chk  = sum_m;
      e.fc   = fc_m & 16'hFFFF;
      e.hact = last_h;
      e.herr = herr_m;
      e.verr = verr_m;
      exp_q.push_back(e);
    end else begin
      locked_m = 1;
    end
    lines_m = 0;
    sum_m   = 0;
    vif.vs    = 1'b0;
    vif.blank = 1'b0;
    wait_n(3);
    vif.vs = 1'b1;
    wait_n(2);
  endtask

  task automatic line(input int npix, input bit vs_end);
    vif.hs = 1'b0;
    wait_n(2);
    vif.hs = 1'b1;
    wait_n(2);
    for (int i = 0; i < npix; i++) begin
      vif.blank = 1'b1;
      vif.rgb   = 24'(i);
      cyc();
    end
    vif.blank = 1'b0;
    vif.rgb   = '0;
    if (locked_m) begin
      for (int i = 0; i < npix; i++) sum_m += 32'(i);
      last_h = npix;
      lines_m++;
      if (npix != 8) herr_m = 1;
    end
    if (vs_end) vsync();
    else wait_n(2);
  endtask

  task automatic frame(input int nlines);
    for (int l = 0; l < nlines; l++) line(8, 1'b0);
  endtask

  // Monitor: every frame_done must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_frame_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("sb_vactive", 32'(vactive_meas), 32'(e.vact));
          chk("sb_checksum", checksum, e.chk);
          chk("sb_frame_count", 32'(frame_count), 32'(e.fc));
          chk("sb_hactive", 32'(hactive_meas), 32'(e.hact));
          chk("sb_h_err", 32'(h_err), 32'(e.herr));
          chk("sb_v_err", 32'(v_err), 32'(e.verr));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.hs    = 1'b1;
    vif.vs    = 1'b1;
    vif.blank = 1'b0;
    vif.rgb   = '0;
    rst       = 1'b1;
    wait_n(3);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_hactive", 32'(hactive_meas), 0);
    chk("rst_vactive", 32'(vactive_meas), 0);
    chk("rst_h_err", 32'(h_err), 0);
    chk("rst_v_err", 32'(v_err), 0);
    chk("rst_checksum", checksum, 0);
    rst = 1'b0;
    wait_n(3);

    vsync();
    chk("lock_first_vs", 32'(locked), 1);
    chk("lock_no_count", 32'(frame_count), 0);

    frame(4);
    vsync();
    wait_n(1);
    chk("clean_checksum_112", checksum, 32'd112);
    chk("clean_vactive_4", 32'(vactive_meas), 4);
    chk("clean_hactive_8", 32'(hactive_meas), 8);
    frame(4);
    vsync();
    frame(4);
    vsync();
    chk("clean_count_3", 32'(frame_count), 3);

    frame(3);
    line(8, 1'b1);
    wait_n(2);
    chk("simul_vactive_4", 32'(vactive_meas), 4);
    chk("simul_v_err_0", 32'(v_err), 0);

    line(8, 1'b0);
    line(7, 1'b0);
    wait_n(2);
    chk("short_hactive_7", 32'(hactive_meas), 7);
    chk("short_h_err_1", 32'(h_err), 1);
    chk("short_v_err_0", 32'(v_err), 0);
    line(8, 1'b0);
    wait_n(2);
    chk("short_next_hactive_8", 32'(hactive_meas), 8);
    line(8, 1'b0);
    vsync();

    frame(5);
    vsync();
    wait_n(1);
    chk("five_v_err_1", 32'(v_err), 1);
    chk("five_vactive_5", 32'(vactive_meas), 5);

    frame(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    locked_m = 0;
    fc_m     = 0;
    herr_m   = 0;
    verr_m   = 0;
    lines_m  = 0;
    sum_m    = 0;
    last_h   = 0;
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_count", 32'(frame_count), 0);
    chk("mid_rst_checksum", checksum, 0);
    chk("mid_rst_h_err", 32'(h_err), 0);
    chk("mid_rst_v_err", 32'(v_err), 0);
    line(8, 1'b0);
    vsync();
    chk("relock_after_rst", 32'(locked), 1);
    chk("relock_no_count", 32'(frame_count), 0);
    frame(4);
    vsync();
    wait_n(1);
    chk("post_rst_count_1", 32'(frame_count), 1);

    line(7, 1'b0);
    frame(3);
    vsync();

    wait_n(4200);
    locked_m = 0;
    lines_m  = 0;
    sum_m    = 0;
    chk("timeout_unlocked", 32'(locked), 0);
    chk("timeout_keep_h_err", 32'(h_err), 1);
    chk("timeout_keep_v_err", 32'(v_err), 0);
    vsync();
    chk("timeout_relock", 32'(locked), 1);
    frame(4);
    vsync();
    wait_n(4);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
